// File: rtl/adc_captura_pkg.sv
// Shared definitions for the AD7476-class ADC capture block.
// Holds the FSM state encoding and the default frame geometry
// used by adc_captura and its serial-clock generator.
package adc_captura_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        QUIET = 2'b10
    } estado_t;

    localparam int DEF_DATA_W  = 12;
    localparam int DEF_FRAME_W = 16;
    localparam int DEF_LEAD_Z  = 4;

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator for the ADC link.
// Divides Clk by 2*CLK_DIV while enabled; SClk idles high when disabled.
// Ports:
//   Clk, Rst   - system clock, synchronous active-low reset
//   en         - run the divider (high only while shifting a frame)
//   sclk       - serial clock register
//   rise_tick  - high on the Clk cycle whose edge takes sclk 0->1
//   fall_tick  - high on the Clk cycle whose edge takes sclk 1->0
module adc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             term;

    assign term      = en && (div == DIV_W'(CLK_DIV - 1));
    // Ticks are combinational so the consumer acts on the same edge as the toggle.
    assign rise_tick = term && !sclk;
    assign fall_tick = term &&  sclk;

    always_ff @(posedge Clk) begin
        if (!Rst || !en) begin
            div  <= '0;
            sclk <= 1'b1;
        end else if (term) begin
            div  <= '0;
            sclk <= ~sclk;
        end else begin
            div  <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/adc_captura.sv
// Serial-to-parallel receiver for the 12-bit SPI-style ADC on the audio Pmod.
// Drives Cs/SClk, shifts in a FRAME_W-bit frame (LEAD_Z zeros then DATA_W
// data bits, MSB first) and presents the sample with a one-cycle strobe.
// Optional: define ADC_DUAL_CH_EN to add the second Pmod channel.
// Ports:
//   Clk, Rst     - system clock, synchronous active-low reset
//   Iniciar      - conversion request, honoured only in IDLE
//   SData        - serial data from the ADC (SData1: second channel)
//   SClk, Cs     - serial clock (idles high) and active-low chip select
//   Data_Out     - last captured sample (Data_Out1: second channel)
//   Rx_Listo     - one-cycle pulse when Data_Out updates
//   Err_Formato  - leading bits of the last frame were not all zero
//   Ocupado      - frame in progress or quiet gap running
module adc_captura
    import adc_captura_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_W   = DEF_FRAME_W,
    parameter int LEAD_Z    = DEF_LEAD_Z,
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Iniciar,
    input  logic              SData,
`ifdef ADC_DUAL_CH_EN
    input  logic              SData1,
    output logic [DATA_W-1:0] Data_Out1,
`endif
    output logic              SClk,
    output logic              Cs,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Rx_Listo,
    output logic              Err_Formato,
    output logic              Ocupado
);

    localparam int QUIET_LEN = QUIET_CYC * 2 * CLK_DIV;
    localparam int BIT_W     = $clog2(FRAME_W + 1);
    localparam int Q_W       = $clog2(QUIET_LEN + 1);

    estado_t              estado, estado_sig;
    logic [BIT_W-1:0]     bit_cnt;
    logic [Q_W-1:0]       q_cnt;
    logic [FRAME_W-1:0]   sr, sr_nuevo;
    logic                 rise_tick, unused_fall_tick;
    logic                 ultimo, q_fin, err_nuevo;

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .Clk       (Clk),
        .Rst       (Rst),
        .en        (estado == SHIFT),
        .sclk      (SClk),
        .rise_tick (rise_tick),
        .fall_tick (unused_fall_tick)
    );

    assign sr_nuevo = {sr[FRAME_W-2:0], SData};
    // Last rising SClk of the frame: the frame completes on this very edge.
    assign ultimo   = rise_tick && (bit_cnt == BIT_W'(FRAME_W - 1));
    assign q_fin    = (q_cnt == Q_W'(QUIET_LEN - 1));

`ifdef ADC_DUAL_CH_EN
    logic [FRAME_W-1:0] sr1, sr1_nuevo;
    assign sr1_nuevo = {sr1[FRAME_W-2:0], SData1};
    assign err_nuevo = (|sr_nuevo[FRAME_W-1 -: LEAD_Z]) | (|sr1_nuevo[FRAME_W-1 -: LEAD_Z]);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sr1       <= '0;
            Data_Out1 <= '0;
        end else if (rise_tick) begin
            sr1 <= sr1_nuevo;
            if (ultimo) Data_Out1 <= sr1_nuevo[DATA_W-1:0];
        end
    end
`else
    assign err_nuevo = |sr_nuevo[FRAME_W-1 -: LEAD_Z];
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) estado <= IDLE;
        else      estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        Cs         = 1'b1;
        Ocupado    = 1'b0;
        case (estado)
            IDLE:  if (Iniciar) estado_sig = SHIFT;
            SHIFT: begin
                Cs      = 1'b0;
                Ocupado = 1'b1;
                if (ultimo) estado_sig = QUIET;
            end
            QUIET: begin
                Ocupado = 1'b1;
                if (q_fin) estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            bit_cnt     <= '0;
            q_cnt       <= '0;
            sr          <= '0;
            Data_Out    <= '0;
            Err_Formato <= 1'b0;
            Rx_Listo    <= 1'b0;
        end else begin
            Rx_Listo <= 1'b0;
            if (estado == IDLE) begin
                bit_cnt <= '0;
                q_cnt   <= '0;
            end
            if (estado == QUIET) q_cnt <= q_cnt + Q_W'(1);
            if (rise_tick) begin
                sr      <= sr_nuevo;
                bit_cnt <= bit_cnt + BIT_W'(1);
                if (ultimo) begin
                    Data_Out    <= sr_nuevo[DATA_W-1:0];
                    Err_Formato <= err_nuevo;
                    Rx_Listo    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/adc_captura.md
Name: adc_captura

Overview:
- Serial-to-parallel receiver for the 12-bit SPI-style ADC on the audio input Pmod (AD7476-class part).
- Generates chip-select (Cs) and serial clock (SClk), shifts in a 16-bit frame: 4 leading zeros followed by 12 data bits, MSB first.
- Presents the 12-bit sample with a one-cycle valid strobe to the equalizer datapath, which in turn feeds the DAC transmitter.

Parameters:
- DATA_W, 12: sample width.
- FRAME_W, 16: SClk periods per frame.
- LEAD_Z, 4: leading zero bits per frame (FRAME_W = LEAD_Z + DATA_W).
- CLK_DIV, 4: Clk cycles per SClk half-period, minimum 1.
- QUIET_CYC, 2: SClk periods Cs stays high after a frame before the next frame may start.

Ports:
- Clk, input, 1: system clock. All logic runs on its rising edge.
- Rst, input, 1: reset, synchronous, active-low.
- Iniciar, input, 1: conversion request, sampled in IDLE only.
- SData, input, 1: serial data from the ADC.
- SClk, output, 1: serial clock to the ADC. Idles high.
- Cs, output, 1: chip select to the ADC, active-low.
- Data_Out, output, DATA_W: last captured sample. Holds its value between frames.
- Rx_Listo, output, 1: one-Clk-cycle pulse when Data_Out updates.
- Err_Formato, output, 1: set when the captured leading bits were not all zero. Updated together with Data_Out.
- Ocupado, output, 1: high in SHIFT and QUIET.

Behaviour:
- Reset (Rst=0 at a rising Clk edge):
  - State goes to IDLE.
  - Cs=1, SClk=1, Data_Out=0, Rx_Listo=0, Err_Formato=0, Ocupado=0.
  - Divider, bit counter and shift register are cleared.
  - Reset applied mid-frame aborts the frame: Cs rises on that edge and no Rx_Listo is produced.
- FSM states:
  - IDLE: if Iniciar=1, go to SHIFT on the next edge with Cs=0, SClk=1, div=0, bit=0. Otherwise stay.
  - SHIFT: div counts 0..CLK_DIV-1. At terminal count, div wraps to 0 and SClk toggles.
    - On a 0->1 SClk toggle, the same edge loads the shift register as {sr[FRAME_W-2:0], SData} and increments bit.
    - When a 0->1 toggle makes bit reach FRAME_W, the same edge also:
      - moves to QUIET and drives Cs=1 (SClk stays 1);
      - loads Data_Out with the new frame's low DATA_W bits;
      - loads Err_Formato with the OR of the new frame's top LEAD_Z bits;
      - sets Rx_Listo=1.
  - QUIET: Rx_Listo returns to 0 after one cycle. Wait QUIET_CYC*2*CLK_DIV Clk cycles, then go to IDLE.
- Iniciar is ignored in SHIFT and QUIET; requests are not queued. Holding Iniciar high gives back-to-back frames separated by the quiet gap plus one IDLE cycle.
- Latency:
  - Cs falls 1 edge after Iniciar is sampled.
  - Rx_Listo rises 2*CLK_DIV*FRAME_W edges after Cs falls. With defaults that is 128, i.e. 129 edges after Iniciar is sampled.
- Sampling point: SData is sampled on the Clk edge where SClk goes high, i.e. mid-bit relative to the ADC's falling-edge launch.
- Counter widths: clog2 sized; no wrap-around occurs inside a frame.

Optional Feature:
- Macro: ADC_DUAL_CH_EN.
- Defined:
  - Adds input SData1 (1 bit) and output Data_Out1 (DATA_W bits), for the second channel of the Pmod.
  - SData1 is sampled on the same edges as SData.
  - Data_Out1 updates on the same Rx_Listo edge.
  - Err_Formato is the OR of both channels' leading-zero checks.
- Undefined: single channel only; the extra ports are absent.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'b00, SHIFT=2'b01, QUIET=2'b10;
  - defaults DATA_W=12, FRAME_W=16, LEAD_Z=4.
- One sub-module: adc_sclk_gen.
  - Divider plus SClk toggle register.
  - Outputs rise_tick and fall_tick pulses.
  - Enabled only in SHIFT.

Test Plan:
1. Reset checks: Rst=0 for 3 cycles in the middle of a frame -> Cs=1, SClk=1, Data_Out=0, Rx_Listo=0 and no Rx_Listo pulse afterwards. Separately, with Rst=1 and Iniciar=0, outputs stay at idle values for 50 cycles.
2. Single capture: ADC model sends 0x0A5C, Iniciar pulsed once -> Cs low for exactly 128 cycles, 16 SClk rising edges, Data_Out=12'hA5C, Err_Formato=0, Rx_Listo high for exactly 1 cycle at edge 129.
3. Format error: model sends 0x8FFF -> Data_Out=12'hFFF, Err_Formato=1. The next frame 0x0001 -> Data_Out=12'h001, Err_Formato=0.
4. Continuous capture: Iniciar held high, model sends 0x0000, then 0x0FFF, then 0x0800 -> three Rx_Listo pulses. Cs is high for 16+1 cycles between frames, with default QUIET_CYC=2 (2*2*CLK_DIV quiet cycles plus one IDLE cycle).
5. Request ignored while busy: Iniciar pulsed in SHIFT and again in QUIET -> no extra frame and no change to Cs timing.
6. CLK_DIV=1 corner: model sends 0x0123 -> SClk toggles every cycle, Data_Out=12'h123 after 32 cycles. With ADC_DUAL_CH_EN defined, SData1 carrying 0x0321 -> Data_Out1=12'h321 on the same Rx_Listo edge.
